// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver.
// Configurable data width, parity and stop bits. Each bit is the 3-sample
// majority vote around mid-bit. Parity and framing errors are reported per
// character.
// Optional feature: define UART_RX_BREAK_DET_EN to add break detection.
// This adds the rx_break port and the BREAK_WAIT state.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
`ifdef UART_RX_BREAK_DET_EN
    output logic                 rx_break,
`endif
    output logic                 rx_busy
);

    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int MID = CLKS_PER_BIT / 2;
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_LO  = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_MID = CW'(MID);
    localparam logic [CW-1:0] CNT_HI  = CW'(MID + 1);
    localparam logic [CW-1:0] CNT_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
`ifdef UART_RX_BREAK_DET_EN
        BREAK_WAIT,
`endif
        STOP
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   rxs_d;
    logic [CW-1:0]          clk_cnt;
    logic [BW-1:0]          bit_idx;
    logic                   stop_idx;
    logic                   s0;
    logic                   s1;
    logic [DATA_BITS-1:0]   data_q;
    logic                   par_bit;
    logic                   pe_q;
    logic                   fe_q;
    logic                   maj;
    logic                   at_hi;
    logic                   at_end;
    logic                   par_exp;

    assign rxs     = sync_q[SYNC_STAGES-1];
    assign maj     = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
    assign at_hi   = (clk_cnt == CNT_HI);
    assign at_end  = (clk_cnt == CNT_END);
    // Even parity bit equals the XOR of the data; odd parity is its inverse.
    assign par_exp = (PARITY_MODE == 1) ? ~(^data_q) : (^data_q);
    assign rx_busy = (state != IDLE);

    // Synchroniser chain plus a delayed copy of rxs for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            rxs_d  <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_serial};
            rxs_d  <= rxs;
        end
    end

    // Capture the first two votes; the third is rxs itself at MID+1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else begin
            if (clk_cnt == CNT_LO)  s0 <= rxs;
            if (clk_cnt == CNT_MID) s1 <= rxs;
        end
    end

    // Receive FSM: bit timing, data assembly, error checks and output strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            data_q     <= '0;
            par_bit    <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            rx_break   <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            rx_break <= 1'b0;
`endif
            if (state != IDLE) clk_cnt <= at_end ? '0 : clk_cnt + 1'b1;
            case (state)
                IDLE: begin
                    clk_cnt  <= '0;
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    par_bit  <= 1'b0;
                    pe_q     <= 1'b0;
                    fe_q     <= 1'b0;
                    if (rxs_d && !rxs) state <= START;
                end
                START: begin
                    // A start bit that votes high was a glitch on the idle line.
                    if (at_hi && maj)  state <= IDLE;
                    else if (at_end)   state <= DATA;
                end
                DATA: begin
                    if (at_hi) data_q[bit_idx] <= maj;
                    if (at_end) begin
                        if (bit_idx == BIT_LAST)
                            state <= (PARITY_MODE != 0) ? PARITY : STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end
                end
                PARITY: begin
                    if (at_hi) begin
                        par_bit <= maj;
                        pe_q    <= (maj != par_exp);
                    end
                    if (at_end) state <= STOP;
                end
                STOP: begin
                    if (at_hi) begin
`ifdef UART_RX_BREAK_DET_EN
                        if (!stop_idx && !maj && (data_q == '0) && !par_bit) begin
                            state    <= BREAK_WAIT;
                            rx_break <= 1'b1;
                        end else
`endif
                        // Leave at mid final stop bit so a fast sender's next
                        // start edge is not missed.
                        if (stop_idx == STOP_LAST) begin
                            state      <= IDLE;
                            rx_valid   <= 1'b1;
                            rx_data    <= data_q;
                            parity_err <= pe_q;
                            frame_err  <= fe_q | ~maj;
                        end else begin
                            fe_q <= fe_q | ~maj;
                        end
                    end else if (at_end) begin
                        stop_idx <= stop_idx + 1'b1;
                    end
                end
`ifdef UART_RX_BREAK_DET_EN
                BREAK_WAIT: begin
                    if (rxs) state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed bench for uart_rx_cfg.
// Instance A is 8N1. Instance B has 7 data bits, even parity and 2 stop bits.
// Both run at 16 clocks per bit.
module tb_uart_rx_cfg;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic line_a = 1'b1;
    logic line_b = 1'b1;

    logic [7:0] data_a;
    logic       valid_a, pe_a, fe_a, busy_a;
    logic [6:0] data_b;
    logic       valid_b, pe_b, fe_b, busy_b;
`ifdef UART_RX_BREAK_DET_EN
    logic       brk_a, brk_b;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0_a = 0, t0_b = 0, lat_a = 0, lat_b = 0;
    int nval_a = 0, nval_b = 0, nfe_a = 0, npe_a = 0, nbrk_a = 0;
    logic [7:0] last_a = 8'h00, prev_a = 8'h00;
    logic busy_at_val = 1'b1;

    uart_rx_cfg #(.CLKS_PER_BIT(16)) dut_a (
        .clk(clk), .reset(reset), .rx_serial(line_a),
        .rx_data(data_a), .rx_valid(valid_a), .parity_err(pe_a), .frame_err(fe_a),
`ifdef UART_RX_BREAK_DET_EN
        .rx_break(brk_a),
`endif
        .rx_busy(busy_a)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset(reset), .rx_serial(line_b),
        .rx_data(data_b), .rx_valid(valid_b), .parity_err(pe_b), .frame_err(fe_b),
`ifdef UART_RX_BREAK_DET_EN
        .rx_break(brk_b),
`endif
        .rx_busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: counts and latency from the start-bit drive to rx_valid.
    always @(negedge clk) begin
        if (valid_a) begin
            nval_a      <= nval_a + 1;
            lat_a       <= cyc - t0_a;
            busy_at_val <= busy_a;
            prev_a      <= last_a;
            last_a      <= data_a;
            if (fe_a) nfe_a <= nfe_a + 1;
            if (pe_a) npe_a <= npe_a + 1;
        end
        if (valid_b) begin
            nval_b <= nval_b + 1;
            lat_b  <= cyc - t0_b;
        end
`ifdef UART_RX_BREAK_DET_EN
        if (brk_a) nbrk_a <= nbrk_a + 1;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive nb bit levels; bit k spans clocks floor(k*per100/100) onward.
    // spike flips the line for one clock; reset is held for clocks [rst_from, rst_to).
    task automatic send(input int sel, input logic [15:0] bits, input int nb, input int per100,
                        input int spike, input int rst_from, input int rst_to);
        int total;
        int k;
        logic lvl;
        total = (nb * per100) / 100;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            if (c == 0) begin
                if (sel == 0) t0_a = cyc;
                else          t0_b = cyc;
            end
            k = 0;
            while ((((k + 1) * per100) / 100 <= c) && (k < nb - 1)) k++;
            lvl = bits[k] ^ (c == spike);
            if (sel == 0) line_a = lvl;
            else          line_b = lvl;
            reset = (c >= rst_from) && (c < rst_to);
        end
    endtask

    task automatic idle(input int n);
        line_a = 1'b1;
        line_b = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data_a", data_a, 0);
        check("rst_valid_a", valid_a, 0);
        check("rst_perr_a", pe_a, 0);
        check("rst_ferr_a", fe_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_busy_b", busy_b, 0);
        reset = 1'b0;
        idle(5);

        // 0xA5, 8N1: latency 3 + 9*16 + 8 + 2 = 157
        send(0, {6'h3f, 1'b1, 8'hA5, 1'b0}, 10, 1600, -1, -1, -1);
        idle(30);
        check("a5_count", nval_a, 1);
        check("a5_data", data_a, 8'hA5);
        check("a5_perr", pe_a, 0);
        check("a5_ferr", fe_a, 0);
        check("a5_busy_at_valid", busy_at_val, 0);
        check("a5_latency", lat_a, 157);

        // 5-clock low glitch on the idle line: start votes high, no frame
        send(0, 16'h0000, 1, 500, -1, -1, -1);
        idle(40);
        check("glitch_count", nval_a, 1);
        check("glitch_busy", busy_a, 0);

        // 0x00 with a one-clock spike on the centre sample of data bit 3
        send(0, {6'h3f, 1'b1, 8'h00, 1'b0}, 10, 1600, 4 * 16 + 9, -1, -1);
        idle(30);
        check("spike_count", nval_a, 2);
        check("spike_data", data_a, 8'h00);
        check("spike_ferr", fe_a, 0);

        // Back-to-back 0x55, 0xFF from a fast sender (15.6 clocks per bit)
        send(0, {6'h3f, 1'b1, 8'h55, 1'b0}, 10, 1560, -1, -1, -1);
        send(0, {6'h3f, 1'b1, 8'hFF, 1'b0}, 10, 1560, -1, -1, -1);
        idle(40);
        check("b2b_count", nval_a, 4);
        check("b2b_first", prev_a, 8'h55);
        check("b2b_second", last_a, 8'hFF);
        check("b2b_ferr_seen", nfe_a, 0);
        check("b2b_perr_seen", npe_a, 0);

        // 0x81 aborted by reset from mid data bit 4, released in the stop bit
        // while the line is high so no fresh falling edge appears.
        send(0, {6'h3f, 1'b1, 8'h81, 1'b0}, 10, 1600, -1, 5 * 16 + 8, 9 * 16 + 4);
        idle(30);
        check("abort_count", nval_a, 4);
        check("abort_data_cleared", data_a, 8'h00);
        check("abort_busy", busy_a, 0);
        send(0, {6'h3f, 1'b1, 8'h42, 1'b0}, 10, 1600, -1, -1, -1);
        idle(30);
        check("after_abort_count", nval_a, 5);
        check("after_abort_data", data_a, 8'h42);
        check("after_abort_ferr", fe_a, 0);

        // 20 low bit-times, line left low
        send(0, 16'h0000, 20, 1600, -1, -1, -1);
`ifdef UART_RX_BREAK_DET_EN
        check("break_pulses", nbrk_a, 1);
        check("break_no_valid", nval_a, 5);
        check("break_waiting", busy_a, 1);
`else
        check("low_count", nval_a, 6);
        check("low_data", data_a, 8'h00);
        check("low_ferr", fe_a, 1);
        check("low_no_retrigger", busy_a, 0);
`endif
        idle(10);
        check("low_released_busy", busy_a, 0);

        // B: 0x07 with parity 0 (even parity wants 1); latency 3 + 10*16 + 10 = 173
        send(1, {5'h1f, 2'b11, 1'b0, 7'h07, 1'b0}, 11, 1600, -1, -1, -1);
        idle(30);
        check("par_bad_count", nval_b, 1);
        check("par_bad_data", data_b, 7'h07);
        check("par_bad_perr", pe_b, 1);
        check("par_bad_ferr", fe_b, 0);
        check("par_latency", lat_b, 173);

        send(1, {5'h1f, 2'b11, 1'b0, 7'h03, 1'b0}, 11, 1600, -1, -1, -1);
        idle(30);
        check("par_ok_data", data_b, 7'h03);
        check("par_ok_perr", pe_b, 0);

        // 0x3C (parity 0 correct) with second stop bit low
        send(1, {5'h1f, 2'b01, 1'b0, 7'h3C, 1'b0}, 11, 1600, -1, -1, -1);
        idle(30);
        check("stop2_count", nval_b, 3);
        check("stop2_data", data_b, 7'h3C);
        check("stop2_ferr", fe_b, 1);
        check("stop2_perr", pe_b, 0);

        send(1, {5'h1f, 2'b11, 1'b0, 7'h11, 1'b0}, 11, 1600, -1, -1, -1);
        idle(30);
        check("stop_ok_data", data_b, 7'h11);
        check("stop_ok_ferr", fe_b, 0);
        check("stop_ok_perr", pe_b, 0);
        check("stop_ok_count", nval_b, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
